// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle for hazard_scoreboard: issue, source operands, stall/forward results.
// Statistics outputs exist only when HAZARD_STATS_EN is defined.
interface hazard_scoreboard_if #(
  parameter int unsigned NREGS  = 16,
  parameter int unsigned STAGES = 3,
  parameter int unsigned LATW   = 2
);
  localparam int unsigned RW = $clog2(NREGS);
  localparam int unsigned FW = $clog2(STAGES + 1);

  logic            hold_i;
  logic            flush_i;
  logic            issue_valid_i;
  logic            issue_wen_i;
  logic [RW-1:0]   issue_dest_i;
  logic [LATW-1:0] issue_lat_i;
  logic            src1_valid_i;
  logic            src2_valid_i;
  logic [RW-1:0]   src1_addr_i;
  logic [RW-1:0]   src2_addr_i;
  logic            stall_o;
  logic [FW-1:0]   fwd1_o;
  logic [FW-1:0]   fwd2_o;
  logic            busy_o;
`ifdef HAZARD_STATS_EN
  logic [31:0]     stall_cnt_o;
  logic [31:0]     fwd_cnt_o;
`endif

  modport master (
    output hold_i,
    output flush_i,
    output issue_valid_i,
    output issue_wen_i,
    output issue_dest_i,
    output issue_lat_i,
    output src1_valid_i,
    output src2_valid_i,
    output src1_addr_i,
    output src2_addr_i,
    input  stall_o,
    input  fwd1_o,
    input  fwd2_o,
    input  busy_o
`ifdef HAZARD_STATS_EN
    ,
    input  stall_cnt_o,
    input  fwd_cnt_o
`endif
  );

  modport slave (
    input  hold_i,
    input  flush_i,
    input  issue_valid_i,
    input  issue_wen_i,
    input  issue_dest_i,
    input  issue_lat_i,
    input  src1_valid_i,
    input  src2_valid_i,
    input  src1_addr_i,
    input  src2_addr_i,
    output stall_o,
    output fwd1_o,
    output fwd2_o,
    output busy_o
`ifdef HAZARD_STATS_EN
    ,
    output stall_cnt_o,
    output fwd_cnt_o
`endif
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Shift-register scoreboard of in-flight writes driving operand forwarding and load-use stall.
// Optional stall/forward statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_scoreboard #(
  parameter int unsigned NREGS        = 16,
  parameter int unsigned STAGES       = 3,
  parameter int unsigned LATW         = 2,
  parameter int unsigned FLUSH_STAGES = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  hazard_scoreboard_if.slave bus
);
  localparam int unsigned RW = $clog2(NREGS);
  localparam int unsigned FW = $clog2(STAGES + 1);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] wen_q, wen_d;
  logic [RW-1:0]     dest_q [STAGES];
  logic [RW-1:0]     dest_d [STAGES];
  logic [LATW-1:0]   cnt_q  [STAGES];
  logic [LATW-1:0]   cnt_d  [STAGES];

  logic [1:0]        src_valid;
  logic [RW-1:0]     src_addr  [2];
  logic [1:0]        src_stall;
  logic [FW-1:0]     src_fwd   [2];
  logic              stall;
  logic [LATW-1:0]   issue_cnt;

  assign src_valid   = {bus.src2_valid_i, bus.src1_valid_i};
  assign src_addr[0] = bus.src1_addr_i;
  assign src_addr[1] = bus.src2_addr_i;

  // Scan oldest to youngest so the youngest matching producer overrides older ones.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      src_stall[i] = 1'b0;
      src_fwd[i]   = '0;
      for (int s = STAGES - 1; s >= 0; s--) begin
        if (valid_q[s] && wen_q[s] && (dest_q[s] == src_addr[i])) begin
          if (cnt_q[s] == '0) begin
            src_fwd[i]   = FW'(s + 1);
            src_stall[i] = 1'b0;
          end else begin
            src_fwd[i]   = '0;
            src_stall[i] = 1'b1;
          end
        end
      end
      if (!src_valid[i]) begin
        src_stall[i] = 1'b0;
        src_fwd[i]   = '0;
      end
    end
  end

  assign stall      = |src_stall;
  assign bus.stall_o = stall;
  assign bus.fwd1_o  = src_fwd[0];
  assign bus.fwd2_o  = src_fwd[1];
  assign bus.busy_o  = |valid_q;

  // Countdown cannot usefully exceed the cycles left before retirement.
  always_comb begin
    if (int'(bus.issue_lat_i) > int'(STAGES) - 1) begin
      issue_cnt = LATW'(STAGES - 1);
    end else begin
      issue_cnt = bus.issue_lat_i;
    end
  end

  always_comb begin
    valid_d = valid_q;
    wen_d   = wen_q;
    dest_d  = dest_q;
    cnt_d   = cnt_q;
    if (!bus.hold_i) begin
      for (int s = 1; s < STAGES; s++) begin
        // Entry leaving stage s-1 is squashed when it sits inside the flush window.
        valid_d[s] = valid_q[s-1] && !(bus.flush_i && (s < int'(FLUSH_STAGES)));
        wen_d[s]   = wen_q[s-1];
        dest_d[s]  = dest_q[s-1];
        cnt_d[s]   = (cnt_q[s-1] == '0) ? '0 : cnt_q[s-1] - LATW'(1);
      end
      valid_d[0] = bus.issue_valid_i && !stall && !bus.flush_i;
      wen_d[0]   = bus.issue_wen_i;
      dest_d[0]  = bus.issue_dest_i;
      cnt_d[0]   = issue_cnt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      wen_q   <= '0;
      for (int s = 0; s < STAGES; s++) begin
        dest_q[s] <= '0;
        cnt_q[s]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      wen_q   <= wen_d;
      for (int s = 0; s < STAGES; s++) begin
        dest_q[s] <= dest_d[s];
        cnt_q[s]  <= cnt_d[s];
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] fwd_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else if (!bus.hold_i) begin
      if (stall) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (bus.issue_valid_i && !stall && ((src_fwd[0] != '0) || (src_fwd[1] != '0))) begin
        fwd_cnt_q <= fwd_cnt_q + 32'd1;
      end
    end
  end

  assign bus.stall_cnt_o = stall_cnt_q;
  assign bus.fwd_cnt_o   = fwd_cnt_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
